// File: rtl/uart_adder_host_pkg.sv
// Shared types and constants for the UART adder host: controller states,
// receiver phases, baud timing and 8N1 frame geometry.
package uart_adder_host_pkg;

  localparam int unsigned HWCLK_HZ          = 12_000_000;
  localparam int unsigned BAUD              = 9600;
  localparam int unsigned CLKS_PER_BIT_9600 = HWCLK_HZ / BAUD;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned FRAME_BITS        = 10;
  localparam int unsigned BIT_CNT_W         = 4;
  localparam int unsigned TMR_W             = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_RECV,
    S_FINISH
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_phase_e;

endpackage

// File: rtl/uart_adder_host_bit_timer.sv
// Loadable bit-period down-counter shared by the transmit and receive paths.
// tick_c marks the end of a full bit period, half_c the midpoint after a load.
module uart_bit_timer
  import uart_adder_host_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
  input  logic hwclk,
  input  logic reset,
  input  logic en,
  input  logic load,
  output logic tick_c,
  output logic half_c
);

  localparam logic [TMR_W-1:0] FULL = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF = TMR_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_c = en && (cnt_q == '0);
    half_c = en && (cnt_q == HALF);
    cnt_d  = cnt_q;
    if (load || tick_c) begin
      cnt_d = FULL;
    end else if (en) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_adder_host.sv
// Host for a UART adder: sends op_a and op_b as 8N1 frames, then receives the
// echoed operands and their 8-bit sum, flagging mismatches and timeouts.
module uart_adder_host
  import uart_adder_host_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] op_a,
  input  logic [BYTE_W-1:0] op_b,
  output logic              tx,
  input  logic              rx,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] sum,
  output logic              mismatch,
  output logic              timeout
);

  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT);

  state_e                  state_q, state_d;
  rx_phase_e               rx_phase_q, rx_phase_d;
  logic [FRAME_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]       rx_shift_q, rx_shift_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [BYTE_W-1:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [BYTE_W-1:0]       echo_a_q, echo_a_d, echo_b_q, echo_b_d;
  logic [BYTE_W-1:0]       last_q, last_d;
  logic [BYTE_W-1:0]       sum_q, sum_d;
  logic                    tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                    mismatch_q, mismatch_d, timeout_q, timeout_d;
  logic                    rx_s1_q, rx_s2_q;
  logic                    tmr_en, tmr_load, tmr_tick_c, tmr_half_c, abort;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .hwclk (hwclk),
    .reset (reset),
    .en    (tmr_en),
    .load  (tmr_load),
    .tick_c(tmr_tick_c),
    .half_c(tmr_half_c)
  );

  always_comb begin
    state_d    = state_q;
    rx_phase_d = rx_phase_q;
    tx_shift_d = tx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_shift_d = rx_shift_q;
    to_cnt_d   = to_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    echo_a_d   = echo_a_q;
    echo_b_d   = echo_b_q;
    last_d     = last_q;
    sum_d      = sum_q;
    mismatch_d = mismatch_q;
    timeout_d  = timeout_q;
    tx_d       = 1'b1;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmr_en     = 1'b0;
    tmr_load   = 1'b0;
    abort      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d     = op_a;
          op_b_d     = op_b;
          tx_shift_d = {1'b1, op_a, 1'b0};
          tx_d       = 1'b0;
          bit_cnt_d  = '0;
          last_d     = '0;
          busy_d     = 1'b1;
          tmr_load   = 1'b1;
          state_d    = S_SEND_A;
        end
      end

      // tx_shift_q[0] is the bit currently on the line
      S_SEND_A, S_SEND_B: begin
        tmr_en = 1'b1;
        tx_d   = tx_q;
        if (tmr_tick_c) begin
          if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            if (state_q == S_SEND_A) begin
              tx_shift_d = {1'b1, op_b_q, 1'b0};
              tx_d       = 1'b0;
              state_d    = S_SEND_B;
            end else begin
              rx_phase_d = RX_IDLE;
              to_cnt_d   = '0;
              byte_cnt_d = '0;
              state_d    = S_RECV;
            end
          end else begin
            tx_shift_d = {1'b1, tx_shift_q[FRAME_BITS-1:1]};
            tx_d       = tx_shift_q[1];
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      S_RECV: begin
        tmr_en = (rx_phase_q != RX_IDLE);
        case (rx_phase_q)
          RX_IDLE: begin
            if (!rx_s2_q) begin
              tmr_load   = 1'b1;
              rx_phase_d = RX_START;
            end else if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
              abort = 1'b1;
            end else begin
              to_cnt_d = to_cnt_q + TO_W'(1);
            end
          end
          // Reload at the start-bit midpoint so later ticks land mid-bit
          RX_START: begin
            if (tmr_half_c) begin
              if (!rx_s2_q) begin
                tmr_load   = 1'b1;
                bit_cnt_d  = '0;
                rx_phase_d = RX_DATA;
              end else begin
                rx_phase_d = RX_IDLE;
              end
            end
          end
          RX_DATA: begin
            if (tmr_tick_c) begin
              rx_shift_d = {rx_s2_q, rx_shift_q[BYTE_W-1:1]};
              bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
              if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                rx_phase_d = RX_STOP;
              end
            end
          end
          RX_STOP: begin
            if (tmr_tick_c) begin
              if (!rx_s2_q) begin
                abort = 1'b1;
              end else begin
                to_cnt_d   = '0;
                rx_phase_d = RX_IDLE;
                last_d     = rx_shift_q;
                byte_cnt_d = byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                  2'd0: echo_a_d = rx_shift_q;
                  2'd1: echo_b_d = rx_shift_q;
                  default: begin
                    sum_d      = rx_shift_q;
                    mismatch_d = (echo_a_q != op_a_q) || (echo_b_q != op_b_q) ||
                                 (rx_shift_q != BYTE_W'(op_a_q + op_b_q));
                    timeout_d  = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_FINISH;
                  end
                endcase
              end
            end
          end
          default: rx_phase_d = RX_IDLE;
        endcase
        if (abort) begin
          sum_d      = last_q;
          mismatch_d = 1'b0;
          timeout_d  = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_FINISH;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rx_phase_q <= RX_IDLE;
      tx_shift_q <= '1;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_shift_q <= '0;
      to_cnt_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      echo_a_q   <= '0;
      echo_b_q   <= '0;
      last_q     <= '0;
      sum_q      <= '0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rx_phase_q <= rx_phase_d;
      tx_shift_q <= tx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_shift_q <= rx_shift_d;
      to_cnt_q   <= to_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      echo_a_q   <= echo_a_d;
      echo_b_q   <= echo_b_d;
      last_q     <= last_d;
      sum_q      <= sum_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign mismatch = mismatch_q;
  assign timeout  = timeout_q;

endmodule

// File: doc/uart_adder_host.md
UART_ADDER_HOST -- requirements
Module: uart_adder_host

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, hwclk cycles per UART bit (12 MHz / 9600 baud); legal range 8..65535.
REQ-002 Parameter TIMEOUT_BITS, default 40, bit-times allowed per awaited response byte before abort.
REQ-003 hwclk  input  1  system clock, 12 MHz; all logic on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to run a transaction; sampled only in IDLE.
REQ-006 op_a  input  8  first operand, captured on accepted start.
REQ-007 op_b  input  8  second operand, captured on accepted start.
REQ-008 tx  output  1  UART line to the adder, 8N1, LSB first, idle high.
REQ-009 rx  input  1  UART line from the adder, asynchronous to hwclk.
REQ-010 busy  output  1  high from the cycle after an accepted start until done pulses.
REQ-011 done  output  1  one-cycle pulse at end of every transaction (good, mismatch or abort).
REQ-012 sum  output  8  third received byte; valid while done is high and held until the next accepted start.
REQ-013 mismatch  output  1  status, updated at done: received bytes differ from {op_a, op_b, op_a+op_b mod 256}.
REQ-014 timeout  output  1  status, updated at done: response byte missing or framing error.

Function
REQ-015 States: IDLE, SEND_A, SEND_B, RECV, FINISH; accepted start in IDLE captures op_a/op_b and moves to SEND_A.
REQ-016 start while busy is ignored; no queuing.
REQ-017 Each transmitted frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-018 SEND_A sends op_a; SEND_B follows with op_b and no idle gap beyond the stop bit; tx is high in all other states.
REQ-019 RECV expects 3 bytes in order: echo A, echo B, sum; byte counter 0..2; FINISH is entered after the third stop bit or on abort.
REQ-020 rx passes through a 2-flop synchronizer before any use; rx is ignored outside RECV.
REQ-021 Start detect: synchronized rx low while the receiver is idle; recheck at CLKS_PER_BIT/2; if high, treat as a glitch and resume waiting.
REQ-022 Data bits are sampled at mid-bit, CLKS_PER_BIT after the start-bit midpoint, and shifted in LSB first.
REQ-023 Stop bit sampled at mid-bit; low causes a framing error: abort to FINISH with timeout=1.
REQ-024 Timeout counter counts from entry into RECV and restarts after each stop bit; reaching TIMEOUT_BITS*CLKS_PER_BIT before a start detect aborts to FINISH with timeout=1.
REQ-025 mismatch is evaluated only when all 3 bytes were received; on abort, mismatch=0 and sum holds the last fully received byte or 0.
REQ-026 Addition is 8-bit with the carry discarded: 200+100 expects 44.
REQ-027 FINISH lasts one cycle: done=1, busy drops in the same cycle, then IDLE.
REQ-028 Latency for a clean run: 5 frames (50*CLKS_PER_BIT) plus the responder turnaround plus 3 cycles of pipeline/synchronizer.

Reset
REQ-029 Reset forces IDLE, tx=1, busy=0, done=0, sum=0, mismatch=0, timeout=0, and clears all counters, shift registers and synchronizer flops to 1.
REQ-030 Reset mid-frame takes effect immediately; a partial tx frame is truncated to idle-high; no done pulse is issued.

Structure
REQ-031 Shared package holds the state encodings, the 12 MHz/9600 CLKS_PER_BIT constant and the 8N1 frame length (10).
REQ-032 One sub-module, uart_bit_timer: loadable down-counter producing bit-tick and half-tick strobes, shared by the tx and rx paths (never active together).

Verification (CLKS_PER_BIT=16, TIMEOUT_BITS=40; a bench model plays the adder)
REQ-033 Good path: start, A=0x03, B=0x04; model replies 03,04,07 -> tx frames 0x03 then 0x04; done with sum=0x07, mismatch=0, timeout=0.
REQ-034 Wrap: A=0xC8, B=0x64; model replies C8,64,2C -> sum=0x2C, mismatch=0.
REQ-035 Bad sum: A=0x10, B=0x20; model replies 10,20,31 -> done, sum=0x31, mismatch=1.
REQ-036 Silent responder after the first byte -> done 40*16 cycles after that stop bit, timeout=1, sum=0x03.
REQ-037 Framing: stop bit of byte 1 driven low -> immediate abort, timeout=1; 4-cycle rx glitch while awaiting a byte is ignored.
REQ-038 Reset asserted mid SEND_B -> tx=1 same cycle, busy=0, no done; a new start afterwards completes normally.
